// File: rtl/sma_v1.sv
// Power-of-two boxcar moving average over a signed 32-bit sample stream.
// One strobe writes the history RAM, then the running sum is updated, then the output.
module sma_v1 #(
  parameter int WINDOW_SIZE = 8192
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic signed [31:0] i_data,
  input  logic               i_update_strobe,
  input  logic        [31:0] i_window_sel,
  output logic signed [31:0] o_data,
  output logic        [31:0] m_count_reg,
  output logic signed [63:0] m_sum_reg,
  output logic        [15:0] m_N,
  output logic signed [31:0] m_data_reg,
  output logic               window_change
);

  localparam int DATA_W  = 32;
  localparam int SUM_W   = 64;
  localparam int MAX_SEL = $clog2(WINDOW_SIZE);
  localparam int SEL_W   = $clog2(MAX_SEL + 1);

  localparam logic [MAX_SEL-1:0] PTR_ONE = 1;
  localparam logic [MAX_SEL:0]   N_ONE   = 1;

  typedef enum logic [1:0] {IDLE, S_ACC, S_OUT} state_t;

  function automatic logic [SEL_W-1:0] clamp_sel(input logic [31:0] s);
    if (s > 32'(MAX_SEL)) return SEL_W'(MAX_SEL);
    return s[SEL_W-1:0];
  endfunction

  function automatic logic signed [SUM_W-1:0] sext(input logic signed [DATA_W-1:0] x);
    return {{(SUM_W-DATA_W){x[DATA_W-1]}}, x};
  endfunction

  function automatic logic signed [DATA_W-1:0] avg_shift(input logic signed [SUM_W-1:0] sum,
                                                         input logic [SEL_W-1:0] sel);
    logic signed [SUM_W-1:0] sh;
    sh = sum >>> sel;
    return sh[DATA_W-1:0];
  endfunction

  state_t                    state_q, state_d;
  logic [SEL_W-1:0]          sel_q, sel_d;
  logic [MAX_SEL-1:0]        wr_ptr_q, wr_ptr_d;
  logic signed [SUM_W-1:0]   sum_q, sum_d;
  logic [31:0]               count_q, count_d;
  logic signed [DATA_W-1:0]  data_q, data_d;
  logic signed [DATA_W-1:0]  odata_q, odata_d;
  logic                      wc_q, wc_d;

  logic [SEL_W-1:0]          sel_new;
  logic [MAX_SEL:0]          n_full;
  logic [31:0]               n32;
  logic [MAX_SEL-1:0]        rd_addr;
  logic                      ram_we;
  logic signed [DATA_W-1:0]  rd_data_q;
  logic signed [DATA_W-1:0]  mem [WINDOW_SIZE];

  assign sel_new = clamp_sel(i_window_sel);
  assign n_full  = N_ONE << sel_q;
  assign n32     = {{(32-MAX_SEL-1){1'b0}}, n_full};
  // At N == WINDOW_SIZE the low bits of N are zero, so the read hits wr_ptr itself.
  assign rd_addr = wr_ptr_q - n_full[MAX_SEL-1:0];

  // Read-before-write: a same-address access returns the sample being overwritten.
  always_ff @(posedge i_clk) begin
    if (ram_we) begin
      mem[wr_ptr_q] <= i_data;
      rd_data_q     <= mem[rd_addr];
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    wr_ptr_d = wr_ptr_q;
    sum_d    = sum_q;
    count_d  = count_q;
    data_d   = data_q;
    odata_d  = odata_q;
    wc_d     = 1'b0;
    ram_we   = 1'b0;
    case (state_q)
      // accept sample, write history, fetch the sample leaving the window
      IDLE: begin
        if (i_update_strobe) begin
          data_d   = i_data;
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          state_d  = S_ACC;
        end else if (sel_new != sel_q) begin
          sel_d   = sel_new;
          wc_d    = 1'b1;
          sum_d   = '0;
          count_d = '0;
        end
      end
      // accumulate
      S_ACC: begin
        sum_d   = sum_q + sext(data_q) - ((count_q == n32) ? sext(rd_data_q) : '0);
        count_d = (count_q < n32) ? count_q + 32'd1 : n32;
        state_d = S_OUT;
      end
      // divide by N
      S_OUT: begin
        odata_d = avg_shift(sum_q, sel_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      wr_ptr_q <= '0;
      sum_q    <= '0;
      count_q  <= '0;
      data_q   <= '0;
      odata_q  <= '0;
      wc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      wr_ptr_q <= wr_ptr_d;
      sum_q    <= sum_d;
      count_q  <= count_d;
      data_q   <= data_d;
      odata_q  <= odata_d;
      wc_q     <= wc_d;
    end
  end

  assign o_data        = odata_q;
  assign m_count_reg   = count_q;
  assign m_sum_reg     = sum_q;
  assign m_N           = {{(16-MAX_SEL-1){1'b0}}, n_full};
  assign m_data_reg    = data_q;
  assign window_change = wc_q;

endmodule

// File: tb/tb_sma_v1.sv
// Scoreboard bench for sma_v1: a window-of-samples reference model predicts each result,
// and a monitor compares when the result appears two edges after an accepted strobe.
module tb_sma_v1;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [31:0] i_data;
  logic               i_update_strobe;
  logic        [31:0] i_window_sel;
  logic signed [31:0] o_data;
  logic        [31:0] m_count_reg;
  logic signed [63:0] m_sum_reg;
  logic        [15:0] m_N;
  logic signed [31:0] m_data_reg;
  logic               window_change;

  sma_v1 dut (
    .i_clk(clk), .i_rst(rst), .i_data(i_data), .i_update_strobe(i_update_strobe),
    .i_window_sel(i_window_sel), .o_data(o_data), .m_count_reg(m_count_reg),
    .m_sum_reg(m_sum_reg), .m_N(m_N), .m_data_reg(m_data_reg), .window_change(window_change)
  );

  always #5 clk = ~clk;

  typedef struct { int o; longint s; int c; } exp_t;
  exp_t   sb[$];
  int     win[$];
  longint msum;
  int     cur_sel;
  int     checks = 0;
  int     errors = 0;
  bit     sb_en  = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the window is the last min(len, N) samples since the last window change.
  function automatic void model_push(input int d);
    win.push_back(d);
    msum += longint'(d);
    if (win.size() > (1 << cur_sel)) msum -= longint'(win.pop_front());
  endfunction

  function automatic exp_t model_expect();
    exp_t   e;
    longint t;
    t   = msum >>> cur_sel;
    e.o = int'(t);
    e.s = msum;
    e.c = win.size();
    return e;
  endfunction

  task automatic do_strobe(input int d);
    @(negedge clk);
    i_data = d;
    i_update_strobe = 1'b1;
    if (sb_en) begin
      model_push(d);
      sb.push_back(model_expect());
    end
    @(negedge clk);
    i_update_strobe = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_sel(input int unsigned s);
    int ns;
    int pulses;
    ns = (s > 13) ? 13 : int'(s);
    @(negedge clk);
    i_window_sel = s;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (window_change) pulses++;
    end
    chk("window_change_pulses", pulses, (ns != cur_sel) ? 1 : 0);
    if (ns != cur_sel) begin
      cur_sel = ns;
      win.delete();
      msum = 0;
      chk("sum_cleared", m_sum_reg, 0);
      chk("count_cleared", m_count_reg, 0);
    end
    chk("m_N", m_N, longint'(1) << cur_sel);
  endtask

  // Monitor: a strobe seen while idle produces its result two edges later.
  initial begin
    int   age;
    exp_t e;
    age = -1;
    forever begin
      @(posedge clk);
      if (rst) age = -1;
      else if (age == 1) begin
        age = -1;
        #1;
        if (sb_en) begin
          if (sb.size() == 0) chk("sb_underflow", 1, 0);
          else begin
            e = sb.pop_front();
            chk("o_data", o_data, e.o);
            chk("m_sum_reg", m_sum_reg, e.s);
            chk("m_count_reg", m_count_reg, e.c);
          end
        end
      end else if (age == 0) age = 1;
      else if (i_update_strobe) age = 0;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    rst = 1'b1;
    i_data = '0;
    i_update_strobe = 1'b0;
    i_window_sel = 12;
    cur_sel = 0;
    msum = 0;
    repeat (3) @(negedge clk);
    chk("rst_o_data", o_data, 0);
    chk("rst_sum", m_sum_reg, 0);
    chk("rst_count", m_count_reg, 0);
    chk("rst_data_reg", m_data_reg, 0);
    chk("rst_wc", window_change, 0);
    chk("rst_m_N", m_N, 1);
    rst = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (window_change) pulses++;
    end
    chk("post_rst_wc", pulses, 1);
    cur_sel = 12;
    chk("m_N_4096", m_N, 4096);
    sb_en = 1'b1;

    for (int k = 0; k < 4146; k++) do_strobe(100);
    @(negedge clk);
    chk("fill12_o_data", o_data, 100);
    chk("fill12_sum", m_sum_reg, 409600);
    chk("fill12_count", m_count_reg, 4096);

    set_sel(10);
    for (int k = 0; k < 1024; k++) do_strobe(100);
    @(negedge clk);
    chk("fill10_o_data", o_data, 100);

    set_sel(8);
    for (int k = 0; k < 300; k++) do_strobe((k % 2 == 0) ? 8191 : -8191);
    @(negedge clk);
    chk("alt_o_data", o_data, 0);
    chk("alt_sum", m_sum_reg, 0);

    set_sel(8);
    for (int p = 0; p < 6; p++) begin
      if ($urandom_range(0, 3) == 0) set_sel($urandom_range(14, 1000));
      else set_sel($urandom_range(0, 13));
      for (int k = 0; k < int'($urandom_range(50, 300)); k++) do_strobe(int'($urandom()));
    end

    set_sel(20);
    chk("clamp_m_N", m_N, 8192);
    for (int k = 0; k < 8192; k++) do_strobe(int'($urandom()));
    for (int k = 0; k < 8192; k++) do_strobe(7);
    @(negedge clk);
    chk("step7_o_data", o_data, 7);

    set_sel(2);
    sb_en = 1'b0;
    @(negedge clk);
    i_data = 40;
    i_update_strobe = 1'b1;
    @(posedge clk); #1;
    chk("E0_data_reg", m_data_reg, 40);
    chk("E0_sum", m_sum_reg, 0);
    @(negedge clk);
    i_data = 99;
    @(posedge clk); #1;
    chk("E1_sum", m_sum_reg, 40);
    chk("E1_count", m_count_reg, 1);
    chk("E1_o_data", o_data, 7);
    chk("E1_data_reg", m_data_reg, 40);
    @(negedge clk);
    i_update_strobe = 1'b0;
    @(posedge clk); #1;
    chk("E2_o_data", o_data, 10);
    repeat (3) @(negedge clk);
    chk("ignored_count", m_count_reg, 1);
    chk("ignored_data_reg", m_data_reg, 40);
    model_push(40);

    @(negedge clk);
    i_data = 50;
    i_update_strobe = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("arst_o_data", o_data, 0);
    chk("arst_sum", m_sum_reg, 0);
    chk("arst_count", m_count_reg, 0);
    chk("arst_data_reg", m_data_reg, 0);
    chk("arst_m_N", m_N, 1);
    @(negedge clk);
    i_update_strobe = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (window_change) pulses++;
    end
    chk("rerst_wc", pulses, 1);
    cur_sel = 2;
    win.delete();
    msum = 0;
    sb_en = 1'b1;
    for (int k = 0; k < 20; k++) do_strobe(int'($urandom()));
    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sma_v1.md
# sma_v1

Power-of-two simple moving average (boxcar) filter for signed 32-bit sample streams, used in the FOG/PIG signal chain to low-pass demodulated data. Each `i_update_strobe` accepts one sample into a circular history buffer. A 64-bit running sum is maintained, and `o_data` is the sum divided by N = 2^sel via an arithmetic shift. The window length can be changed at run time; each change restarts the average.

## Interface
- `WINDOW_SIZE`, 8192: history depth and maximum N; must be a power of two. `MAX_SEL` = log2(`WINDOW_SIZE`) = 13.
- `i_clk` input 1: single clock; all state updates on the rising edge.
- `i_rst` input 1: reset, asynchronous and active-high.
- `i_data` input 32: signed two's-complement sample.
- `i_update_strobe` input 1: one-cycle-high strobe; each high cycle presents one new sample.
- `i_window_sel` input 32: requested log2(N), unsigned.
- `o_data` output 32: signed moving average.
- `m_count_reg` output 32: number of valid samples in the window, 0..N.
- `m_sum_reg` output 64: signed running sum.
- `m_N` output 16: effective window length N.
- `m_data_reg` output 32: last accepted sample.
- `window_change` output 1: one-cycle pulse when the effective window changes.

## Operation
- Effective select `sel` = min(`i_window_sel`, `MAX_SEL`), held in register `sel_reg`; `m_N` = 1 << `sel_reg`.
- Memory: `WINDOW_SIZE` x 32 RAM with a registered read. On a same-address collision the read returns the OLD data.
- Write pointer `wr_ptr` is `MAX_SEL` bits wide and wraps naturally modulo `WINDOW_SIZE`.
- Read address = (`wr_ptr` - N) mod `WINDOW_SIZE`, which is the sample leaving the window. At N = `WINDOW_SIZE` this equals `wr_ptr` (collision rule applies).
- Three-state pipeline: IDLE -> S_ACC -> S_OUT -> IDLE.
  - IDLE, strobe high:
    - `m_data_reg` <= `i_data`.
    - RAM[`wr_ptr`] <= `i_data`.
    - Issue the read of the old address.
    - `wr_ptr`++ and go to S_ACC.
  - S_ACC:
    - `m_sum_reg` <= `m_sum_reg` + sext(`m_data_reg`) - (`m_count_reg` == N ? sext(old) : 0).
    - `m_count_reg` <= min(`m_count_reg` + 1, N).
    - Go to S_OUT.
  - S_OUT:
    - `o_data` <= low 32 bits of (`m_sum_reg` >>> `sel_reg`), arithmetic shift.
    - Go to IDLE.
- Strobes arriving in S_ACC or S_OUT are ignored. Upstream must space strobes at least 3 cycles apart.
- During fill (count < N) nothing is subtracted. `o_data` is then the partial sum / N, so it ramps up linearly toward the input.
- Window change, evaluated only in IDLE with no strobe in the same cycle (a strobe takes priority and the change is taken at the next IDLE cycle). If `sel` != `sel_reg`:
  - `sel_reg` <= `sel`; `window_change` = 1 for that one cycle.
  - `m_sum_reg` <= 0; `m_count_reg` <= 0.
  - `o_data` and `wr_ptr` hold.
  - Stale RAM contents are never subtracted, because subtraction starts only once count reaches N again.
- Sum width: 64 bits cannot overflow (2^13 x 2^31 < 2^63).

## Timing
- Reset values:
  - `o_data`, `m_sum_reg`, `m_count_reg`, `m_data_reg`, `wr_ptr`, `window_change` = 0.
  - `sel_reg` = 0, so `m_N` = 1; state = IDLE.
  - RAM contents are not reset.
- On the first IDLE cycle after reset, `sel_reg` loads `sel`, pulsing `window_change` if `sel` != 0.
- Latency: strobe sampled at edge E0.
  - `m_data_reg` updates at E0.
  - `m_sum_reg` and `m_count_reg` update at E1.
  - `o_data` updates at E2.
- `window_change` is a registered single-cycle pulse.
- Reset asserted mid-pipeline aborts immediately to reset values. No partial update survives.

## Test plan
- Reset, sel = 12, `i_data` = 100 constant, strobes every 111 cycles:
  - `m_N` = 4096 and one `window_change` pulse after reset.
  - After k strobes, `o_data` = floor(100·k/4096); reaches 100 at k = 4096 and holds 100; `m_sum_reg` = 409600; `m_count_reg` saturates at 4096.
- Change sel 12 -> 10 in steady state:
  - One `window_change` pulse; sum and count cleared; `m_N` = 1024.
  - `o_data` re-ramps and equals 100 after 1024 further strobes.
- sel = 8 with an alternating ±8191 input: `o_data` settles to 0 once count = 256; the sum never grows.
- `i_window_sel` = 20 -> clamps to sel = 13, `m_N` = 8192. A step input of 7 after fill: `o_data` = 7 exactly 8192 strobes later, which checks the collision read-old rule.
- Strobe at edge E0: `m_data_reg` changes at E0, `m_sum_reg` at E1, `o_data` at E2. A second strobe at E1 is ignored, so count increments once.
- Assert `i_rst` between E0 and E2: all outputs return to 0 asynchronously, and accumulation restarts cleanly after release.
